// File: rtl/norm_pkg.sv
// Shared types and helpers for the normalizer result serializer.
package norm_pkg;

    // Width of one normalized quotient for a given normalizer element width.
    function automatic int result_width(input int datawidth);
        return 2 * datawidth + 2;
    endfunction

    // Serializer control states.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Component index of a serial beat: 0=A, 1=B, 2=C, 3=D.
    typedef logic [1:0] comp_idx_t;

    localparam comp_idx_t FIRST_IDX = 2'd0;
    localparam comp_idx_t LAST_IDX  = 2'd3;

endpackage

// File: rtl/norm_result_serializer_if.sv
// Bundle of the per-component result inputs and the serial beat outputs.
interface norm_result_serializer_if #(
    parameter int DATAWIDTH  = 4,
    parameter int FIFO_DEPTH = 4
);
    import norm_pkg::*;

    localparam int RW = result_width(DATAWIDTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          i_valid_A;
    logic          i_valid_B;
    logic          i_valid_C;
    logic          i_valid_D;
    logic [RW-1:0] i_q_A;
    logic [RW-1:0] i_q_B;
    logic [RW-1:0] i_q_C;
    logic [RW-1:0] i_q_D;
    logic          i_ready;
    logic          i_clr_flags;

    logic          o_valid;
    logic [RW-1:0] o_data;
    comp_idx_t     o_idx;
    logic          o_last;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_misalign;

    // Producer/consumer side: drives the divider results and downstream ready.
    modport master (
        output i_valid_A, i_valid_B, i_valid_C, i_valid_D,
        output i_q_A, i_q_B, i_q_C, i_q_D,
        output i_ready, i_clr_flags,
        input  o_valid, o_data, o_idx, o_last, o_count, o_overflow, o_misalign
    );

    // Serializer side.
    modport slave (
        input  i_valid_A, i_valid_B, i_valid_C, i_valid_D,
        input  i_q_A, i_q_B, i_q_C, i_q_D,
        input  i_ready, i_clr_flags,
        output o_valid, o_data, o_idx, o_last, o_count, o_overflow, o_misalign
    );

endinterface

// File: rtl/norm_vec_fifo.sv
// Result-vector buffer: DEPTH entries, pointers carry an extra wrap bit so
// full and empty are distinguishable. A push into a full FIFO is accepted
// when a pop happens in the same cycle.
module norm_vec_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign count    = count_q;

    // Pointer and occupancy bookkeeping; the count is kept as its own register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/norm_result_serializer.sv
// Collects the four normalized quotients of a result vector and streams them
// out as four registered beats A, B, C, D. The vector being sent lives in a
// holding register; the FIFO only buffers vectors waiting behind it, so the
// first beat of a vector arriving at an idle serializer appears one clock later.
module norm_result_serializer
    import norm_pkg::*;
#(
    parameter int DATAWIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    norm_result_serializer_if.slave  bus
);

    localparam int RW = result_width(DATAWIDTH);
    localparam int VW = 4 * RW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ser_state_t    state_q, state_d;
    logic [VW-1:0] vec_q, vec_d;
    comp_idx_t     idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [RW-1:0] data_q, data_d;
    logic          last_q, last_d;
    logic          overflow_q;
    logic          misalign_q;

    logic          all_valid;
    logic          any_valid;
    logic [VW-1:0] in_vec;
    logic          handshake;
    logic          bypass;
    logic          fifo_push;
    logic          fifo_pop;
    logic [VW-1:0] fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          overflow_evt;
    logic          misalign_evt;

    assign all_valid = bus.i_valid_A & bus.i_valid_B & bus.i_valid_C & bus.i_valid_D;
    assign any_valid = bus.i_valid_A | bus.i_valid_B | bus.i_valid_C | bus.i_valid_D;
    assign in_vec    = {bus.i_q_D, bus.i_q_C, bus.i_q_B, bus.i_q_A};
    assign handshake = valid_q && bus.i_ready;

    assign fifo_push    = all_valid && !bypass;
    assign overflow_evt = fifo_push && fifo_full && !fifo_pop;
    assign misalign_evt = any_valid && !all_valid;

    norm_vec_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_vec),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state and next-beat selection: a new vector goes straight into the
    // holding register when nothing is queued ahead of it, otherwise the FIFO
    // head is promoted on the last-beat handshake.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        bypass   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (all_valid) begin
                    bypass  = 1'b1;
                    vec_d   = in_vec;
                    idx_d   = FIRST_IDX;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = comp_idx_t'(idx_q + 2'd1);
                    end else begin
                        idx_d = FIRST_IDX;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            vec_d    = fifo_data;
                        end else if (all_valid) begin
                            bypass = 1'b1;
                            vec_d  = in_vec;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        data_d = valid_d ? vec_d[int'(idx_d) * RW +: RW] : '0;
        last_d = valid_d && (idx_d == LAST_IDX);
    end

    // Serializer state and registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= FIRST_IDX;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Sticky error flags; a fresh error wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (overflow_evt) begin
                overflow_q <= 1'b1;
            end else if (bus.i_clr_flags) begin
                overflow_q <= 1'b0;
            end
            if (misalign_evt) begin
                misalign_q <= 1'b1;
            end else if (bus.i_clr_flags) begin
                misalign_q <= 1'b0;
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_data     = data_q;
    assign bus.o_idx      = idx_q;
    assign bus.o_last     = last_q;
    assign bus.o_count    = fifo_count;
    assign bus.o_overflow = overflow_q;
    assign bus.o_misalign = misalign_q;

endmodule

// File: tb/tb_norm_result_serializer.sv
// Directed bench for the normalizer result serializer. Inputs change on the
// falling edge, outputs are inspected on the falling edge as well.
module tb_norm_result_serializer;
    import norm_pkg::*;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int RW    = 2 * DW + 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    norm_result_serializer_if #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    norm_result_serializer #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drop all divider valids and the flag clear.
    task automatic set_idle();
        bus.i_valid_A   = 1'b0;
        bus.i_valid_B   = 1'b0;
        bus.i_valid_C   = 1'b0;
        bus.i_valid_D   = 1'b0;
        bus.i_q_A       = '0;
        bus.i_q_B       = '0;
        bus.i_q_C       = '0;
        bus.i_q_D       = '0;
        bus.i_clr_flags = 1'b0;
    endtask

    // Present one aligned result vector for the coming clock edge.
    task automatic drive_vec(input int a, input int b, input int c, input int d);
        bus.i_valid_A = 1'b1;
        bus.i_valid_B = 1'b1;
        bus.i_valid_C = 1'b1;
        bus.i_valid_D = 1'b1;
        bus.i_q_A     = RW'(a);
        bus.i_q_B     = RW'(b);
        bus.i_q_C     = RW'(c);
        bus.i_q_D     = RW'(d);
    endtask

    task automatic test_reset();
        logic [18:0] snap;
        rst         = 1'b1;
        bus.i_ready = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        snap = {bus.o_valid, bus.o_data, bus.o_idx, bus.o_last,
                bus.o_count, bus.o_overflow, bus.o_misalign};
        total++;
        if (snap !== 19'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want 0", snap);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.o_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release_valid: got %b want 0", bus.o_valid);
        end
    endtask

    task automatic test_single();
        int exp_d [4] = '{9, 12, 0, 0};
        bus.i_ready = 1'b1;
        drive_vec(9, 12, 0, 0);
        @(negedge clk);
        set_idle();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== RW'(exp_d[i]) ||
                bus.o_idx !== 2'(i) || bus.o_last !== (i == 3)) begin
                bad++;
                $display("[TB] FAIL single_beat%0d: got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                         i, bus.o_valid, bus.o_data, bus.o_idx, bus.o_last, exp_d[i], i, (i == 3));
            end
            @(negedge clk);
        end
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== CW'(0)) begin
            bad++;
            $display("[TB] FAIL single_done: got v=%b cnt=%0d want v=0 cnt=0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_backpressure();
        bus.i_ready = 1'b1;
        drive_vec(5, 12, 7, 3);
        @(negedge clk);
        set_idle();
        total++;
        if (bus.o_data !== RW'(5) || bus.o_idx !== 2'd0) begin
            bad++;
            $display("[TB] FAIL bp_beat0: got d=%0d i=%0d want d=5 i=0", bus.o_data, bus.o_idx);
        end
        @(negedge clk);
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== RW'(12) || bus.o_idx !== 2'd1 || bus.o_last !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d: got v=%b d=%0d i=%0d l=%b want v=1 d=12 i=1 l=0",
                         i, bus.o_valid, bus.o_data, bus.o_idx, bus.o_last);
            end
            if (i < 3) @(negedge clk);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.o_data !== RW'(7) || bus.o_idx !== 2'd2) begin
            bad++;
            $display("[TB] FAIL bp_beat2: got d=%0d i=%0d want d=7 i=2", bus.o_data, bus.o_idx);
        end
        @(negedge clk);
        total++;
        if (bus.o_data !== RW'(3) || bus.o_idx !== 2'd3 || bus.o_last !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_beat3: got d=%0d i=%0d l=%b want d=3 i=3 l=1", bus.o_data, bus.o_idx, bus.o_last);
        end
        @(negedge clk);
        total++;
        if (bus.o_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_done: got v=%b want 0", bus.o_valid);
        end
    endtask

    task automatic test_overflow();
        bus.i_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive_vec(10 * k, 10 * k + 1, 10 * k + 2, 10 * k + 3);
            @(negedge clk);
        end
        set_idle();
        total++;
        if (bus.o_count !== CW'(4) || bus.o_overflow !== 1'b1 || bus.o_misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_state: got cnt=%0d ovf=%b mis=%b want cnt=4 ovf=1 mis=0",
                     bus.o_count, bus.o_overflow, bus.o_misalign);
        end
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            for (int c = 0; c < 4; c++) begin
                total++;
                if (bus.o_valid !== 1'b1 || bus.o_data !== RW'(10 * k + c) || bus.o_idx !== 2'(c)) begin
                    bad++;
                    $display("[TB] FAIL ovf_drain v%0d b%0d: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                             k, c, bus.o_valid, bus.o_data, bus.o_idx, 10 * k + c, c);
                end
                @(negedge clk);
            end
        end
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== CW'(0) || bus.o_overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovf_after: got v=%b cnt=%0d ovf=%b want v=0 cnt=0 ovf=1",
                     bus.o_valid, bus.o_count, bus.o_overflow);
        end
        bus.i_clr_flags = 1'b1;
        @(negedge clk);
        bus.i_clr_flags = 1'b0;
        total++;
        if (bus.o_overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_clear: got %b want 0", bus.o_overflow);
        end
    endtask

    task automatic test_push_pop_full();
        bus.i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive_vec(100 + 10 * k, 101 + 10 * k, 102 + 10 * k, 103 + 10 * k);
            @(negedge clk);
        end
        set_idle();
        total++;
        if (bus.o_count !== CW'(4)) begin
            bad++;
            $display("[TB] FAIL ppf_full: got cnt=%0d want 4", bus.o_count);
        end
        bus.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        drive_vec(160, 161, 162, 163);
        @(negedge clk);
        set_idle();
        total++;
        if (bus.o_overflow !== 1'b0 || bus.o_count !== CW'(4)) begin
            bad++;
            $display("[TB] FAIL ppf_accept: got ovf=%b cnt=%0d want ovf=0 cnt=4", bus.o_overflow, bus.o_count);
        end
        for (int k = 2; k <= 6; k++) begin
            for (int c = 0; c < 4; c++) begin
                total++;
                if (bus.o_valid !== 1'b1 || bus.o_data !== RW'(100 + 10 * k + c) || bus.o_last !== (c == 3)) begin
                    bad++;
                    $display("[TB] FAIL ppf_drain v%0d b%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                             k, c, bus.o_valid, bus.o_data, bus.o_last, 100 + 10 * k + c, (c == 3));
                end
                @(negedge clk);
            end
        end
        total++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== CW'(0)) begin
            bad++;
            $display("[TB] FAIL ppf_done: got v=%b cnt=%0d want v=0 cnt=0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_misalign();
        bus.i_ready   = 1'b1;
        bus.i_valid_A = 1'b1;
        bus.i_valid_B = 1'b1;
        bus.i_q_A     = RW'(33);
        bus.i_q_B     = RW'(44);
        @(negedge clk);
        set_idle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.o_misalign !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_count !== CW'(0)) begin
                bad++;
                $display("[TB] FAIL mis_set%0d: got mis=%b v=%b cnt=%0d want mis=1 v=0 cnt=0",
                         i, bus.o_misalign, bus.o_valid, bus.o_count);
            end
            @(negedge clk);
        end
        bus.i_clr_flags = 1'b1;
        bus.i_valid_C   = 1'b1;
        @(negedge clk);
        set_idle();
        total++;
        if (bus.o_misalign !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mis_priority: got %b want 1", bus.o_misalign);
        end
        bus.i_clr_flags = 1'b1;
        @(negedge clk);
        bus.i_clr_flags = 1'b0;
        total++;
        if (bus.o_misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mis_clear: got %b want 0", bus.o_misalign);
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] snap;
        bus.i_ready = 1'b1;
        drive_vec(1, 2, 3, 4);
        @(negedge clk);
        drive_vec(5, 6, 7, 8);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        total++;
        if (bus.o_idx !== 2'd2 || bus.o_data !== RW'(3) || bus.o_count !== CW'(1)) begin
            bad++;
            $display("[TB] FAIL rmid_pre: got i=%0d d=%0d cnt=%0d want i=2 d=3 cnt=1",
                     bus.o_idx, bus.o_data, bus.o_count);
        end
        rst = 1'b1;
        #1;
        snap = {bus.o_valid, bus.o_data, bus.o_idx, bus.o_last,
                bus.o_count, bus.o_overflow, bus.o_misalign};
        total++;
        if (snap !== 19'd0) begin
            bad++;
            $display("[TB] FAIL rmid_async: got %h want 0", snap);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (bus.o_valid !== 1'b0 || bus.o_count !== CW'(0)) begin
                bad++;
                $display("[TB] FAIL rmid_residual%0d: got v=%b cnt=%0d want v=0 cnt=0",
                         i, bus.o_valid, bus.o_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_push_pop_full();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
